uart_bus_port: RTL and testbench



---
 rtl/uart_bus_port.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_uart_bus_port.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_port.sv
// uart_bus_port: memory-mapped 8N1 UART responder for the CPU peripheral bus.
// Registers: TXD (write byte to send), RXD (last received byte), CON (enables and status).
// The baud rate comes from a fixed divisor. rdata and hit are combinational address decodes.
// The serial line and all status flags are held in flops.

module uart_bus_port #(
    parameter int          BAUD_DIV = 10417,
    parameter logic [31:0] BASE     = 32'h40000018
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    input  logic        UART_RX,
    output logic        UART_TX,
    output logic        irq
);

    localparam int            CW        = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [31:0]   TXD_ADDR  = BASE;
    localparam logic [31:0]   RXD_ADDR  = BASE + 32'd4;
    localparam logic [31:0]   CON_ADDR  = BASE + 32'd8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Bus decode and strobes
    logic sel_txd_s, sel_rxd_s, sel_con_s;
    logic txd_wr_s, con_wr_s, con_rd_s, rxd_rd_s;

    // Control / status registers
    logic       tx_ie_r, rx_ie_r, tx_done_r, rx_ready_r, rx_overrun_r;
    logic [7:0] rx_data_r;
    logic       tx_busy_s;
    logic [31:0] con_val_s;

    // TX path
    tx_state_t  tx_state_r, tx_state_next_s;
    logic [CW-1:0] tx_cnt_r, tx_cnt_next_s;
    logic [2:0] tx_bit_r, tx_bit_next_s;
    logic [7:0] tx_shift_r, tx_shift_next_s;
    logic       tx_line_r, tx_line_next_s;
    logic       tx_done_set_s;

    // RX path
    logic       rx_s1_r, rx_s2_r, rx_prev_r;
    logic       rx_fall_s;
    rx_state_t  rx_state_r, rx_state_next_s;
    logic [CW-1:0] rx_cnt_r, rx_cnt_next_s;
    logic [2:0] rx_bit_r, rx_bit_next_s;
    logic [7:0] rx_shift_r, rx_shift_next_s;
    logic       rx_ready_set_s;
    logic       rx_overrun_set_s;

    // Only the low byte of write data is meaningful
    logic unused_wdata_s;
    assign unused_wdata_s = ^wdata[31:8];

    assign sel_txd_s = (addr == TXD_ADDR);
    assign sel_rxd_s = (addr == RXD_ADDR);
    assign sel_con_s = (addr == CON_ADDR);
    assign hit       = sel_txd_s | sel_rxd_s | sel_con_s;

    assign txd_wr_s  = wr & sel_txd_s;
    assign con_wr_s  = wr & sel_con_s;
    assign con_rd_s  = rd & sel_con_s;
    assign rxd_rd_s  = rd & sel_rxd_s;

    assign tx_busy_s = (tx_state_r != TX_IDLE);
    assign con_val_s = {26'd0, rx_overrun_r, tx_busy_s, rx_ready_r, tx_done_r, rx_ie_r, tx_ie_r};

    // Interrupt is a pure function of registered enables and flags
    assign irq     = (tx_ie_r & tx_done_r) | (rx_ie_r & rx_ready_r);
    assign UART_TX = tx_line_r;

    // Read data mux: zero unless a read strobe hits a readable register
    always_comb begin
        rdata = 32'd0;
        if (!rd) begin
            rdata = 32'd0;
        end else if (sel_rxd_s) begin
            rdata = {24'd0, rx_data_r};
        end else if (sel_con_s) begin
            rdata = con_val_s;
        end else begin
            rdata = 32'd0;
        end
    end

    // Control/status register updates; a flag set beats a read-clear in the same cycle
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            tx_ie_r      <= 1'b0;
            rx_ie_r      <= 1'b0;
            tx_done_r    <= 1'b0;
            rx_ready_r   <= 1'b0;
            rx_overrun_r <= 1'b0;
            rx_data_r    <= 8'd0;
        end else begin
            if (con_wr_s) begin
                tx_ie_r <= wdata[0];
                rx_ie_r <= wdata[1];
            end
            if (tx_done_set_s) begin
                tx_done_r <= 1'b1;
            end else if (con_rd_s) begin
                tx_done_r <= 1'b0;
            end
            if (rx_ready_set_s) begin
                rx_ready_r <= 1'b1;
                rx_data_r  <= rx_shift_r;
            end else if (rxd_rd_s) begin
                rx_ready_r <= 1'b0;
            end
            if (rx_overrun_set_s) begin
                rx_overrun_r <= 1'b1;
            end else if (con_rd_s) begin
                rx_overrun_r <= 1'b0;
            end
        end
    end

    // TX state register; reset forces the line idle high immediately
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= CNT_ZERO;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'd0;
            tx_line_r  <= 1'b1;
        end else begin
            tx_state_r <= tx_state_next_s;
            tx_cnt_r   <= tx_cnt_next_s;
            tx_bit_r   <= tx_bit_next_s;
            tx_shift_r <= tx_shift_next_s;
            tx_line_r  <= tx_line_next_s;
        end
    end

    // TX next-state: each state/bit holds for BAUD_DIV cycles; line value is precomputed
    always_comb begin
        tx_state_next_s = tx_state_r;
        tx_cnt_next_s   = tx_cnt_r;
        tx_bit_next_s   = tx_bit_r;
        tx_shift_next_s = tx_shift_r;
        tx_line_next_s  = tx_line_r;
        tx_done_set_s   = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                if (txd_wr_s) begin
                    tx_state_next_s = TX_START;
                    tx_cnt_next_s   = FULL_LOAD;
                    tx_shift_next_s = wdata[7:0];
                    tx_line_next_s  = 1'b0;
                end else begin
                    tx_line_next_s  = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt_r == CNT_ZERO) begin
                    tx_state_next_s = TX_DATA;
                    tx_cnt_next_s   = FULL_LOAD;
                    tx_bit_next_s   = 3'd0;
                    tx_line_next_s  = tx_shift_r[0];
                end else begin
                    tx_cnt_next_s   = tx_cnt_r - CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt_r == CNT_ZERO) begin
                    tx_cnt_next_s = FULL_LOAD;
                    if (tx_bit_r == 3'd7) begin
                        tx_state_next_s = TX_STOP;
                        tx_line_next_s  = 1'b1;
                    end else begin
                        tx_bit_next_s   = tx_bit_r + 3'd1;
                        tx_shift_next_s = {1'b0, tx_shift_r[7:1]};
                        tx_line_next_s  = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_next_s = tx_cnt_r - CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_cnt_r == CNT_ZERO) begin
                    tx_state_next_s = TX_IDLE;
                    tx_line_next_s  = 1'b1;
                    tx_done_set_s   = 1'b1;
                end else begin
                    tx_cnt_next_s   = tx_cnt_r - CNT_ONE;
                end
            end
            default: begin
                tx_state_next_s = TX_IDLE;
                tx_line_next_s  = 1'b1;
            end
        endcase
    end

    // Two-flop synchronizer plus previous-value flop for falling-edge detection
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_s1_r   <= 1'b1;
            rx_s2_r   <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_s1_r   <= UART_RX;
            rx_s2_r   <= rx_s1_r;
            rx_prev_r <= rx_s2_r;
        end
    end

    assign rx_fall_s        = rx_prev_r & ~rx_s2_r;
    assign rx_overrun_set_s = rx_ready_set_s & rx_ready_r;

    // RX state register
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= CNT_ZERO;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'd0;
        end else begin
            rx_state_r <= rx_state_next_s;
            rx_cnt_r   <= rx_cnt_next_s;
            rx_bit_r   <= rx_bit_next_s;
            rx_shift_r <= rx_shift_next_s;
        end
    end

    // RX next-state: half-bit wait to mid start bit, then one sample per bit period
    always_comb begin
        rx_state_next_s = rx_state_r;
        rx_cnt_next_s   = rx_cnt_r;
        rx_bit_next_s   = rx_bit_r;
        rx_shift_next_s = rx_shift_r;
        rx_ready_set_s  = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                if (rx_fall_s) begin
                    rx_state_next_s = RX_START;
                    rx_cnt_next_s   = HALF_LOAD;
                end else begin
                    rx_state_next_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_r == CNT_ZERO) begin
                    if (rx_s2_r) begin
                        rx_state_next_s = RX_IDLE;
                    end else begin
                        rx_state_next_s = RX_DATA;
                        rx_cnt_next_s   = FULL_LOAD;
                        rx_bit_next_s   = 3'd0;
                    end
                end else begin
                    rx_cnt_next_s = rx_cnt_r - CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_r == CNT_ZERO) begin
                    rx_cnt_next_s   = FULL_LOAD;
                    rx_shift_next_s = {rx_s2_r, rx_shift_r[7:1]};
                    if (rx_bit_r == 3'd7) begin
                        rx_state_next_s = RX_STOP;
                    end else begin
                        rx_bit_next_s   = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_next_s = rx_cnt_r - CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt_r == CNT_ZERO) begin
                    rx_state_next_s = RX_IDLE;
                    if (rx_s2_r) begin
                        rx_ready_set_s = 1'b1;
                    end else begin
                        rx_ready_set_s = 1'b0;
                    end
                end else begin
                    rx_cnt_next_s = rx_cnt_r - CNT_ONE;
                end
            end
            default: begin
                rx_state_next_s = RX_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_bus_port.sv
// Directed testbench for uart_bus_port with a short baud divisor.

module tb_uart_bus_port;

    localparam int          BD   = 8;
    localparam logic [31:0] BASE = 32'h40000018;
    localparam logic [31:0] TXD  = BASE;
    localparam logic [31:0] RXD  = BASE + 32'd4;
    localparam logic [31:0] CON  = BASE + 32'd8;

    logic        sysclk;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;
    logic        UART_RX;
    logic        UART_TX;
    logic        irq;

    int check_count = 0;
    int error_count = 0;

    uart_bus_port #(.BAUD_DIV(BD), .BASE(BASE)) dut (
        .sysclk  (sysclk),
        .reset   (reset),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .hit     (hit),
        .UART_RX (UART_RX),
        .UART_TX (UART_TX),
        .irq     (irq)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; the strobe is sampled on the following posedge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wr = 1'b1;
        addr = a;
        wdata = d;
        @(negedge sysclk);
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        rd = 1'b1;
        addr = a;
        #1;
        d = rdata;
        @(negedge sysclk);
        rd = 1'b0;
    endtask

    // Checks UART_TX cycle by cycle; cycle 0 is the negedge right after the TXD write edge
    task automatic check_tx_frame(input logic [7:0] d, input int first_c, input int con_c);
        logic [9:0] fr;
        fr = {1'b1, d, 1'b0};
        for (int c = first_c; c < 10 * BD; c++) begin
            if (c == con_c) begin
                rd = 1'b1;
                addr = CON;
            end
            #1;
            check_eq($sformatf("tx_bit_c%0d", c), {31'd0, UART_TX}, {31'd0, fr[c / BD]});
            if (c == con_c) begin
                check_eq("con_during_tx", rdata, 32'h00000010);
            end
            @(negedge sysclk);
            rd = 1'b0;
        end
    endtask

    // Drives one frame on UART_RX and reports the first cycle irq was seen high
    task automatic send_rx(input logic [7:0] d, input logic stop_bit, output int ready_c);
        logic [9:0] fr;
        fr = {stop_bit, d, 1'b0};
        ready_c = -1;
        for (int c = 0; c < 10 * BD + 10; c++) begin
            UART_RX = (c < 10 * BD) ? fr[c / BD] : 1'b1;
            #1;
            if (irq && ready_c < 0) begin
                ready_c = c;
            end
            @(negedge sysclk);
        end
    endtask

    logic [31:0] rv;
    int          lat;

    initial begin
        reset = 1'b0;
        rd = 1'b0;
        wr = 1'b0;
        addr = 32'd0;
        wdata = 32'd0;
        UART_RX = 1'b1;

        // Reset held: pin activity must not disturb outputs
        repeat (3) @(negedge sysclk);
        UART_RX = 1'b0;
        wr = 1'b1;
        addr = TXD;
        wdata = 32'h000000A5;
        @(negedge sysclk);
        wr = 1'b0;
        UART_RX = 1'b1;
        rd = 1'b1;
        addr = CON;
        #1;
        check_eq("rst_tx", {31'd0, UART_TX}, 32'd1);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        check_eq("rst_con", rdata, 32'd0);
        rd = 1'b0;
        @(negedge sysclk);
        reset = 1'b1;
        repeat (20) @(negedge sysclk);
        #1;
        check_eq("idle_tx", {31'd0, UART_TX}, 32'd1);
        @(negedge sysclk);
        bus_read(CON, rv);
        check_eq("idle_con", rv, 32'd0);

        // Address decode
        addr = TXD;        #1; check_eq("hit_txd", {31'd0, hit}, 32'd1);
        addr = RXD;        #1; check_eq("hit_rxd", {31'd0, hit}, 32'd1);
        addr = CON;        #1; check_eq("hit_con", {31'd0, hit}, 32'd1);
        addr = BASE + 32'd12; #1; check_eq("hit_past", {31'd0, hit}, 32'd0);
        addr = BASE + 32'd2;  #1; check_eq("hit_unaligned", {31'd0, hit}, 32'd0);
        @(negedge sysclk);
        bus_read(BASE + 32'd12, rv);
        check_eq("rdata_nohit", rv, 32'd0);

        // CON write touches only the enable bits
        bus_write(CON, 32'hFFFFFFFF);
        bus_read(CON, rv);
        check_eq("con_wr_mask", rv, 32'h00000003);
        check_eq("con_wr_irq", {31'd0, irq}, 32'd0);
        bus_write(CON, 32'h00000000);

        // TX frame 0xA5
        bus_write(TXD, 32'h000000A5);
        check_tx_frame(8'hA5, 0, 20);
        bus_read(CON, rv);
        check_eq("con_after_tx", rv, 32'h00000004);
        bus_read(CON, rv);
        check_eq("con_clear_done", rv, 32'h00000000);

        // Write while busy is dropped
        bus_write(TXD, 32'h00000055);
        @(negedge sysclk);
        @(negedge sysclk);
        bus_write(TXD, 32'h000000FF);
        check_tx_frame(8'h55, 3, 10);
        for (int i = 0; i < 4; i++) begin
            repeat (5) @(negedge sysclk);
            #1;
            check_eq("tx_idle_after_drop", {31'd0, UART_TX}, 32'd1);
        end
        @(negedge sysclk);
        bus_read(CON, rv);
        check_eq("con_drop_done", rv, 32'h00000004);
        bus_read(CON, rv);
        check_eq("con_drop_once", rv, 32'h00000000);

        // RX 0x3C with latency check through irq
        bus_write(CON, 32'h00000002);
        send_rx(8'h3C, 1'b1, lat);
        check_eq("rx_latency_in_window", {31'd0, (lat >= 3 + BD / 2 + 9 * BD - 1) && (lat <= 3 + BD / 2 + 9 * BD + 1)}, 32'd1);
        bus_read(RXD, rv);
        check_eq("rxd_3c", rv, 32'h0000003C);
        #1;
        check_eq("irq_after_rxd", {31'd0, irq}, 32'd0);
        bus_read(CON, rv);
        check_eq("con_after_rxd", rv, 32'h00000002);

        // Overrun
        send_rx(8'h11, 1'b1, lat);
        send_rx(8'h22, 1'b1, lat);
        #1;
        check_eq("irq_overrun", {31'd0, irq}, 32'd1);
        @(negedge sysclk);
        bus_read(CON, rv);
        check_eq("con_overrun", rv, 32'h0000002A);
        bus_read(RXD, rv);
        check_eq("rxd_22", rv, 32'h00000022);
        #1;
        check_eq("irq_cleared", {31'd0, irq}, 32'd0);
        @(negedge sysclk);
        bus_read(CON, rv);
        check_eq("con_after_overrun", rv, 32'h00000002);

        // Short glitch on RX
        UART_RX = 1'b0;
        repeat (2) @(negedge sysclk);
        UART_RX = 1'b1;
        repeat (20) @(negedge sysclk);
        bus_read(CON, rv);
        check_eq("con_glitch", rv, 32'h00000002);

        // Framing error: stop bit low
        send_rx(8'h7E, 1'b0, lat);
        bus_read(CON, rv);
        check_eq("con_framing", rv, 32'h00000002);
        check_eq("irq_framing", {31'd0, irq}, 32'd0);
        bus_read(RXD, rv);
        check_eq("rxd_kept", rv, 32'h00000022);

        // Reset in the middle of a TX frame
        bus_write(TXD, 32'h00000000);
        repeat (20) @(negedge sysclk);
        #1;
        check_eq("tx_low_mid", {31'd0, UART_TX}, 32'd0);
        reset = 1'b0;
        #1;
        check_eq("tx_async_rst", {31'd0, UART_TX}, 32'd1);
        check_eq("irq_async_rst", {31'd0, irq}, 32'd0);
        rd = 1'b1;
        addr = CON;
        #1;
        check_eq("con_in_rst", rdata, 32'd0);
        rd = 1'b0;
        @(negedge sysclk);
        reset = 1'b1;
        repeat (30) @(negedge sysclk);
        #1;
        check_eq("tx_after_rst", {31'd0, UART_TX}, 32'd1);
        @(negedge sysclk);
        bus_read(CON, rv);
        check_eq("con_after_rst", rv, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
